// File: rtl/input_debouncer_if.sv
// Input debouncer bus: raw level in, debounced level, busy flag and edge strobes out.
// Latency: none (wires only).
// Backpressure: none; all signals are plain levels/strobes with no handshake.
interface input_debouncer_if;
  logic i_data;  // raw asynchronous level
  logic o_data;  // debounced level
  logic o_busy;  // candidate change under qualification
  logic o_rise;  // one-cycle strobe on debounced 0->1
  logic o_fall;  // one-cycle strobe on debounced 1->0

  // Consumer/stimulus side: drives the raw level, observes the results.
  modport master (
    output i_data,
    input  o_data,
    input  o_busy,
    input  o_rise,
    input  o_fall
  );

  // Debouncer side.
  modport slave (
    input  i_data,
    output o_data,
    output o_busy,
    output o_rise,
    output o_fall
  );
endinterface

// File: rtl/input_debouncer.sv
// Debounces a raw asynchronous level: synchronizer chain, then a stable-window FSM.
// Latency: o_data follows a clean change SYNC_STAGES+CNT_STABLE edges after it is first sampled.
// Backpressure: none; free-running. Optional edge strobes under macro DEBOUNCE_EDGE_PULSE_EN.
module input_debouncer #(
  parameter int SYNC_STAGES = 2,      // 2..4
  parameter int CNT_STABLE  = 10_000  // >= 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input_debouncer_if.slave bus
);

  localparam int CW = $clog2(CNT_STABLE + 1);
  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_STABLE - 1);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    CHECK_HIGH  = 2'd1,
    STABLE_HIGH = 2'd2,
    CHECK_LOW   = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic                   data_q;
  logic                   busy_q;

  // Synchronizer chain; only the last stage is ever used downstream.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.i_data};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef DEBOUNCE_EDGE_PULSE_EN
  logic rise_q;
  logic fall_q;
`endif

  // Qualification FSM; every output is registered alongside the state so
  // nothing downstream sees a combinational path from the input.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= STABLE_LOW;
      cnt_q   <= CNT_ZERO;
      data_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef DEBOUNCE_EDGE_PULSE_EN
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
`endif
    end else begin
`ifdef DEBOUNCE_EDGE_PULSE_EN
      // Strobes last exactly one cycle unless re-asserted below.
      rise_q <= 1'b0;
      fall_q <= 1'b0;
`endif
      case (state_q)
        STABLE_LOW: begin
          data_q <= 1'b0;
          busy_q <= 1'b0;
          cnt_q  <= CNT_ZERO;
          if (s) begin
            state_q <= CHECK_HIGH;
            cnt_q   <= CNT_ONE;
            busy_q  <= 1'b1;
          end
        end

        CHECK_HIGH: begin
          if (!s) begin
            // Level fell back before the window closed: abandon the candidate.
            state_q <= STABLE_LOW;
            cnt_q   <= CNT_ZERO;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= STABLE_HIGH;
            cnt_q   <= CNT_ZERO;
            data_q  <= 1'b1;
            busy_q  <= 1'b0;
`ifdef DEBOUNCE_EDGE_PULSE_EN
            rise_q  <= 1'b1;
`endif
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        STABLE_HIGH: begin
          data_q <= 1'b1;
          busy_q <= 1'b0;
          cnt_q  <= CNT_ZERO;
          if (!s) begin
            state_q <= CHECK_LOW;
            cnt_q   <= CNT_ONE;
            busy_q  <= 1'b1;
          end
        end

        CHECK_LOW: begin
          if (s) begin
            // Level came back high before the window closed.
            state_q <= STABLE_HIGH;
            cnt_q   <= CNT_ZERO;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= STABLE_LOW;
            cnt_q   <= CNT_ZERO;
            data_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef DEBOUNCE_EDGE_PULSE_EN
            fall_q  <= 1'b1;
`endif
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        default: begin
          // Recover from any corrupted encoding to the reset state.
          state_q <= STABLE_LOW;
          cnt_q   <= CNT_ZERO;
          data_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_data = data_q;
  assign bus.o_busy = busy_q;

`ifdef DEBOUNCE_EDGE_PULSE_EN
  assign bus.o_rise = rise_q;
  assign bus.o_fall = fall_q;
`else
  // Edge strobes are not built in this configuration.
  assign bus.o_rise = 1'b0;
  assign bus.o_fall = 1'b0;
`endif

endmodule
